// File: rtl/multi_tone_sound_pkg.sv
// Shared constants, channel configuration type and helpers for the multi-tone
// buzzer driver.
package multi_tone_sound_pkg;

    localparam int SND_TICK_DIV_50MHZ = 50000;
    localparam int SND_COUNT_WIDTH    = 26;
    localparam int SND_DUR_WIDTH      = 16;

    typedef struct packed {
        logic [SND_COUNT_WIDTH-1:0] max_count;
        logic [SND_DUR_WIDTH-1:0]   duration;
    } snd_chan_cfg_t;

    // Channel-select width; a single channel still gets a 1-bit select.
    function automatic int snd_sel_width(input int channels);
        return (channels > 1) ? $clog2(channels) : 1;
    endfunction

endpackage

// File: rtl/multi_tone_sound_if.sv
// CPU-side programming and status bus of the multi-tone buzzer driver.
interface multi_tone_sound_if
    import multi_tone_sound_pkg::*;
#(
    parameter int CHANNELS    = 4,
    parameter int COUNT_WIDTH = SND_COUNT_WIDTH,
    parameter int DUR_WIDTH   = SND_DUR_WIDTH
);
    localparam int SEL_W = snd_sel_width(CHANNELS);

    // load is a one-cycle strobe with no ready: ch_sel/max_count/duration are
    // sampled on the edge where load=1 and the block always accepts them.
    logic [SEL_W-1:0]       ch_sel;
    logic [COUNT_WIDTH-1:0] max_count;
    logic [DUR_WIDTH-1:0]   duration;
    logic                   load;
    logic [CHANNELS-1:0]    busy;
    logic [CHANNELS-1:0]    done;

    modport master (
        output ch_sel, max_count, duration, load,
        input  busy, done
    );

    modport slave (
        input  ch_sel, max_count, duration, load,
        output busy, done
    );

endinterface

// File: rtl/multi_tone_sound_tone_channel.sv
// One square-wave tone channel: phase counter, square bit, optional timed
// duration, with a load that always wins over expiry.
module tone_channel
    import multi_tone_sound_pkg::*;
#(
    parameter int COUNT_WIDTH = SND_COUNT_WIDTH,
    parameter int DUR_WIDTH   = SND_DUR_WIDTH
) (
    input  logic                   clk,
    input  logic                   n_rst_async,
    input  logic                   i_tick,
    input  logic                   i_load,
    input  logic [COUNT_WIDTH-1:0] i_max_count,
    input  logic [DUR_WIDTH-1:0]   i_duration,
    output logic                   o_busy,
    output logic                   o_done,
    output logic                   o_square
);
    logic [COUNT_WIDTH-1:0] r_period;
    logic [COUNT_WIDTH-1:0] r_phase;
    logic [DUR_WIDTH-1:0]   r_remaining;
    logic                   r_busy;
    logic                   r_done;
    logic                   r_square;
    logic                   w_expire;
    logic                   w_wrap;

    // remaining is 0 in continuous mode, so only timed notes can expire.
    assign w_expire = r_busy && i_tick && (r_remaining == DUR_WIDTH'(1));
    assign w_wrap   = (r_phase == r_period - COUNT_WIDTH'(1));

    always_ff @(posedge clk or negedge n_rst_async) begin
        if (!n_rst_async) begin
            r_period    <= '0;
            r_phase     <= '0;
            r_remaining <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_square    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (i_load) begin
                r_phase  <= '0;
                r_square <= 1'b0;
                if (i_max_count != '0) begin
                    r_busy      <= 1'b1;
                    r_period    <= i_max_count;
                    r_remaining <= i_duration;
                end else begin
                    r_busy      <= 1'b0;
                    r_remaining <= '0;
                end
            end else if (w_expire) begin
                r_busy      <= 1'b0;
                r_done      <= 1'b1;
                r_phase     <= '0;
                r_square    <= 1'b0;
                r_remaining <= '0;
            end else if (r_busy) begin
                if (w_wrap) begin
                    r_phase  <= '0;
                    r_square <= ~r_square;
                end else begin
                    r_phase <= r_phase + COUNT_WIDTH'(1);
                end
                if (i_tick && (r_remaining != '0)) begin
                    r_remaining <= r_remaining - DUR_WIDTH'(1);
                end
            end
        end
    end

    assign o_busy   = r_busy;
    assign o_done   = r_done;
    assign o_square = r_square;

endmodule

// File: rtl/multi_tone_sound.sv
// Multi-channel buzzer driver: duration-tick prescaler, load decode, and a
// first-order sigma-delta mixer folding all channel squares onto one pin.
module multi_tone_sound
    import multi_tone_sound_pkg::*;
#(
    parameter int CHANNELS    = 4,
    parameter int COUNT_WIDTH = SND_COUNT_WIDTH,
    parameter int DUR_WIDTH   = SND_DUR_WIDTH,
    parameter int TICK_DIV    = SND_TICK_DIV_50MHZ
) (
    input  logic              clk,
    input  logic              n_rst_async,
    multi_tone_sound_if.slave bus,
    output logic              buzzer
);
    localparam int SEL_W = snd_sel_width(CHANNELS);
    localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int ACC_W = $clog2(2 * CHANNELS);

    logic [PRE_W-1:0]    r_presc;
    logic                w_tick;
    logic [CHANNELS-1:0] w_load;
    logic [CHANNELS-1:0] w_busy;
    logic [CHANNELS-1:0] w_done;
    logic [CHANNELS-1:0] w_square;
    logic [ACC_W-1:0]    r_acc;
    logic [ACC_W-1:0]    w_sum;
    logic [ACC_W-1:0]    w_acc_next;
    logic                r_buzzer;

    // Free-running: loads never realign it, so timed notes land within one tick.
    assign w_tick = (r_presc == PRE_W'(TICK_DIV - 1));

    always_ff @(posedge clk or negedge n_rst_async) begin
        if (!n_rst_async) begin
            r_presc <= '0;
        end else if (w_tick) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + PRE_W'(1);
        end
    end

    genvar c;
    for (c = 0; c < CHANNELS; c++) begin : g_ch
        // Selects at or above CHANNELS match no channel and are dropped.
        assign w_load[c] = bus.load && (bus.ch_sel == SEL_W'(c));

        tone_channel #(
            .COUNT_WIDTH (COUNT_WIDTH),
            .DUR_WIDTH   (DUR_WIDTH)
        ) u_ch (
            .clk         (clk),
            .n_rst_async (n_rst_async),
            .i_tick      (w_tick),
            .i_load      (w_load[c]),
            .i_max_count (bus.max_count),
            .i_duration  (bus.duration),
            .o_busy      (w_busy[c]),
            .o_done      (w_done[c]),
            .o_square    (w_square[c])
        );
    end

    assign bus.busy = w_busy;
    assign bus.done = w_done;

    always_comb begin
        w_sum = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            w_sum = w_sum + ACC_W'(w_busy[i] & w_square[i]);
        end
    end

    // acc stays below CHANNELS, so acc+sum fits in ACC_W bits.
    assign w_acc_next = r_acc + w_sum;

    always_ff @(posedge clk or negedge n_rst_async) begin
        if (!n_rst_async) begin
            r_acc    <= '0;
            r_buzzer <= 1'b0;
        end else if (w_acc_next >= ACC_W'(CHANNELS)) begin
            r_acc    <= w_acc_next - ACC_W'(CHANNELS);
            r_buzzer <= 1'b1;
        end else begin
            r_acc    <= w_acc_next;
            r_buzzer <= 1'b0;
        end
    end

    assign buzzer = r_buzzer;

endmodule

// File: tb/tb_multi_tone_sound.sv
// Bench for multi_tone_sound: a 4-channel and a 1-channel instance checked
// every cycle against a tick/period arithmetic model plus directed literals.
module tb_multi_tone_sound;
    import multi_tone_sound_pkg::*;

    localparam int T = 10;

    logic clk = 1'b0;
    logic n_rst = 1'b0;
    logic buzzer4;
    logic buzzer1;

    int total = 0;
    int bad   = 0;

    multi_tone_sound_if #(.CHANNELS(4)) bus4 ();
    multi_tone_sound_if #(.CHANNELS(1)) bus1 ();

    multi_tone_sound #(.CHANNELS(4), .TICK_DIV(T)) dut4 (
        .clk         (clk),
        .n_rst_async (n_rst),
        .bus         (bus4.slave),
        .buzzer      (buzzer4)
    );

    multi_tone_sound #(.CHANNELS(1), .TICK_DIV(T)) dut1 (
        .clk         (clk),
        .n_rst_async (n_rst),
        .bus         (bus1.slave),
        .buzzer      (buzzer1)
    );

    always #5 clk = ~clk;

    // ---------------- model: slots 0..3 = dut4 channels, slot 4 = dut1 ch0
    int unsigned m_j;
    bit          m_act[5];
    int unsigned m_per[5];
    int unsigned m_ld[5];
    int unsigned m_end[5];
    bit          m_done[5];
    int          m_acc[2];
    bit          m_buz[2];

    // After n edges since the load edge the square is floor(n/period) mod 2.
    function automatic bit m_sq(input int s);
        if (!m_act[s]) return 1'b0;
        return bit'(((m_j - m_ld[s]) / m_per[s]) % 2);
    endfunction

    initial forever begin
        @(posedge clk or negedge n_rst);
        if (!n_rst) begin
            m_j = 0;
            for (int s = 0; s < 5; s++) begin
                m_act[s] = 0; m_per[s] = 1; m_ld[s] = 0; m_end[s] = 0; m_done[s] = 0;
            end
            m_acc[0] = 0; m_acc[1] = 0; m_buz[0] = 0; m_buz[1] = 0;
        end else begin
            int sum;
            sum = 0;
            for (int s = 0; s < 4; s++) sum += int'(m_sq(s));
            m_acc[1] += sum;
            m_buz[1] = (m_acc[1] >= 4);
            if (m_buz[1]) m_acc[1] -= 4;
            m_acc[0] += int'(m_sq(4));
            m_buz[0] = (m_acc[0] >= 1);
            if (m_buz[0]) m_acc[0] -= 1;
            m_j++;
            for (int s = 0; s < 5; s++) begin
                bit ld;
                int unsigned mc;
                int unsigned du;
                if (s < 4) begin
                    ld = bus4.load && (int'(bus4.ch_sel) == s);
                    mc = bus4.max_count; du = bus4.duration;
                end else begin
                    ld = bus1.load && (bus1.ch_sel == 1'b0);
                    mc = bus1.max_count; du = bus1.duration;
                end
                m_done[s] = 0;
                if (ld) begin
                    m_act[s] = (mc != 0);
                    m_per[s] = (mc != 0) ? mc : 1;
                    m_ld[s]  = m_j;
                    m_end[s] = (du == 0) ? 0 : ((m_j / T) + 1) * T + (du - 1) * T;
                end else if (m_act[s] && m_end[s] != 0 && m_j == m_end[s]) begin
                    m_act[s]  = 0;
                    m_done[s] = 1;
                end
            end
        end
    end

    // ---------------- scoreboard
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, m_j);
        end
    endtask

    initial forever begin
        @(negedge clk);
        if (n_rst) begin
            logic [3:0] eb;
            logic [3:0] ed;
            for (int s = 0; s < 4; s++) begin
                eb[s] = m_act[s]; ed[s] = m_done[s];
            end
            check("busy4", 32'(bus4.busy), 32'(eb));
            check("done4", 32'(bus4.done), 32'(ed));
            check("buzzer4", 32'(buzzer4), 32'(m_buz[1]));
            check("busy1", 32'(bus1.busy), 32'(m_act[4]));
            check("done1", 32'(bus1.done), 32'(m_done[4]));
            check("buzzer1", 32'(buzzer1), 32'(m_buz[0]));
        end
    end

    // ---------------- drivers
    task automatic load4(input int sel, input snd_chan_cfg_t cfg);
        @(negedge clk);
        bus4.ch_sel = 2'(sel); bus4.max_count = cfg.max_count;
        bus4.duration = cfg.duration; bus4.load = 1'b1;
        @(negedge clk);
        bus4.load = 1'b0;
    endtask

    task automatic load1(input int sel, input snd_chan_cfg_t cfg);
        @(negedge clk);
        bus1.ch_sel = 1'(sel); bus1.max_count = cfg.max_count;
        bus1.duration = cfg.duration; bus1.load = 1'b1;
        @(negedge clk);
        bus1.load = 1'b0;
    endtask

    function automatic snd_chan_cfg_t mk(input int mc, input int du);
        snd_chan_cfg_t c;
        c.max_count = SND_COUNT_WIDTH'(mc);
        c.duration  = SND_DUR_WIDTH'(du);
        return c;
    endfunction

    bit samp[2000];

    initial begin
        int cnt;
        int viol;
        int unsigned l0;
        bit seen;
        bus4.ch_sel = '0; bus4.max_count = '0; bus4.duration = '0; bus4.load = 1'b0;
        bus1.ch_sel = '0; bus1.max_count = '0; bus1.duration = '0; bus1.load = 1'b0;
        repeat (3) @(negedge clk);
        n_rst = 1'b1;

        // 1: reset mid-note
        load4(0, mk(3, 5));
        repeat (7) @(negedge clk);
        @(posedge clk);
        #2 n_rst = 1'b0;
        #1;
        check("rst_busy4", 32'(bus4.busy), 0);
        check("rst_done4", 32'(bus4.done), 0);
        check("rst_buzzer4", 32'(buzzer4), 0);
        repeat (3) @(negedge clk);
        n_rst = 1'b1;
        cnt = 0;
        repeat (80) begin @(negedge clk); cnt += int'(bus4.done != 0); end
        check("rst_no_done", 32'(cnt), 0);

        // 2: single-channel continuous square, period 6
        load1(0, mk(3, 0));
        repeat (4) @(negedge clk);
        for (int k = 0; k < 1200; k++) begin
            @(negedge clk);
            samp[k] = buzzer1;
        end
        cnt = 0; viol = 0;
        for (int k = 0; k < 1200; k++) cnt += int'(samp[k]);
        for (int k = 0; k < 1197; k++) viol += int'(samp[k] == samp[k + 3]);
        check("t2_high_cycles", 32'(cnt), 600);
        check("t2_half_period", 32'(viol), 0);
        check("t2_busy", 32'(bus1.busy), 1);

        // 3: timed channel expires on the 3rd tick after load
        load4(1, mk(2, 3));
        l0 = m_j;
        seen = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (!bus4.busy[1]) begin seen = 1; break; end
        end
        check("t3_fell", 32'(seen), 1);
        check("t3_interval", 32'((m_j - l0 >= 20) && (m_j - l0 <= 30)), 1);
        check("t3_done_hi", 32'(bus4.done[1]), 1);
        @(negedge clk);
        check("t3_done_lo", 32'(bus4.done[1]), 0);

        // 4: two channels, 50% mix during the common high half
        load4(0, mk(1000, 0));
        load4(1, mk(1000, 0));
        for (int k = 0; k < 2000; k++) begin
            @(negedge clk);
            samp[k] = buzzer4;
        end
        cnt = 0;
        for (int k = 100; k < 900; k++) cnt += int'(samp[k]);
        check("t4_low_half", 32'(cnt), 0);
        cnt = 0; viol = 0;
        for (int k = 1100; k < 1900; k++) cnt += int'(samp[k]);
        for (int k = 1100; k < 1899; k++) viol += int'(samp[k] == samp[k + 1]);
        check("t4_high_duty", 32'(cnt), 400);
        check("t4_alternate", 32'(viol), 0);
        load4(0, mk(0, 0));
        load4(1, mk(0, 0));

        // 5: stop with max_count=0; out-of-range select ignored
        load4(2, mk(5, 0));
        repeat (20) @(negedge clk);
        load4(2, mk(0, 0));
        check("t5_stop", 32'(bus4.busy[2]), 0);
        cnt = 0;
        repeat (50) begin @(negedge clk); cnt += int'(bus4.done[2]); end
        check("t5_no_done", 32'(cnt), 0);
        load1(1, mk(0, 0));
        check("t5_oor_ignored", 32'(bus1.busy), 1);
        repeat (20) @(negedge clk);

        // 6: reload lands on the expiring tick
        load4(0, mk(4, 1));
        while (((m_j + 1) % T) != 0) @(negedge clk);
        bus4.ch_sel = 2'd0; bus4.max_count = 26'd3; bus4.duration = 16'd0; bus4.load = 1'b1;
        @(negedge clk);
        bus4.load = 1'b0;
        check("t6_busy", 32'(bus4.busy[0]), 1);
        check("t6_no_done", 32'(bus4.done[0]), 0);
        repeat (30) @(negedge clk);
        load4(0, mk(0, 0));

        // random traffic against the model
        for (int n = 0; n < 250; n++) begin
            if ($urandom_range(0, 1) == 0)
                load4($urandom_range(0, 3), mk($urandom_range(0, 9), $urandom_range(0, 4)));
            else
                load1($urandom_range(0, 1), mk($urandom_range(0, 9), $urandom_range(0, 4)));
            repeat ($urandom_range(0, 25)) @(negedge clk);
        end
        repeat (60) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
